// File: rtl/voice_allocator_pkg.sv
// voice_alloc_pkg: voice and controller state types shared by the voice allocator,
// plus an index-width helper that never returns zero.
package voice_alloc_pkg;
    typedef enum logic [1:0] {V_IDLE, V_HELD, V_RELEASING} voice_state_t;
    typedef enum logic {ST_IDLE, ST_COMMIT} ctrl_state_t;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: note-event valid/ready bus between the MIDI parser (master)
// and the voice allocator (slave).
interface voice_allocator_if #(
    parameter int NOTE_WIDTH = 7,
    parameter int RATE_WIDTH = 24
);
    logic                  event_valid_in;
    logic                  event_ready_out;
    logic                  note_on_in;
    logic [NOTE_WIDTH-1:0] note_in;
    logic [RATE_WIDTH-1:0] rate_in;
    modport master(output event_valid_in, note_on_in, note_in, rate_in, input event_ready_out);
    modport slave(input event_valid_in, note_on_in, note_in, rate_in, output event_ready_out);
endinterface

// File: rtl/voice_allocator_select.sv
// voice_select: picks the voice for a note-on -- held retrigger, else lowest idle,
// else oldest releasing, else oldest held; age ties resolve to the lowest index.
module voice_select
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_WIDTH = 7,
    parameter int AGE_WIDTH = 16,
    localparam int IW = idx_width(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]                 held,
    input  logic [NUM_VOICES-1:0]                 releasing,
    input  logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] notes,
    input  logic [NUM_VOICES-1:0][AGE_WIDTH-1:0]  ages,
    input  logic [NOTE_WIDTH-1:0]                 note,
    output logic [IW-1:0]                         idx,
    output logic                                  steal
);
    logic hit_m, hit_i, hit_r, hit_h;
    logic [IW-1:0] i_m, i_i, i_r, i_h;
    logic [AGE_WIDTH-1:0] a_r, a_h;
    always_comb begin
        hit_m = 1'b0;
        hit_i = 1'b0;
        hit_r = 1'b0;
        hit_h = 1'b0;
        i_m = '0;
        i_i = '0;
        i_r = '0;
        i_h = '0;
        a_r = '0;
        a_h = '0;
        // ascending scan with strict '>' keeps the lowest index on equal ages
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (held[v] && notes[v] == note && !hit_m) begin
                hit_m = 1'b1;
                i_m = IW'(v);
            end
            if (!held[v] && !releasing[v] && !hit_i) begin
                hit_i = 1'b1;
                i_i = IW'(v);
            end
            if (releasing[v] && (!hit_r || ages[v] > a_r)) begin
                hit_r = 1'b1;
                i_r = IW'(v);
                a_r = ages[v];
            end
            if (held[v] && (!hit_h || ages[v] > a_h)) begin
                hit_h = 1'b1;
                i_h = IW'(v);
                a_h = ages[v];
            end
        end
        idx = hit_m ? i_m : hit_i ? i_i : hit_r ? i_r : i_h;
        steal = !hit_m && !hit_i;
    end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns MIDI note events to oscillator voices with age-based stealing.
// Define VOICE_ALLOCATOR_SUSTAIN_EN to add the sustain_in pedal input.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_WIDTH = 7,
    parameter int RATE_WIDTH = 24,
    parameter int AGE_WIDTH = 16,
    parameter int RELEASE_CYCLES = 4800,
    localparam int IW = idx_width(NUM_VOICES),
    localparam int CNTW = $clog2(NUM_VOICES + 1)
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    voice_allocator_if.slave                 ev,
    input  logic                             all_off_in,
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    input  logic                             sustain_in,
`endif
    output logic [NUM_VOICES-1:0]            voice_gate_out,
    output logic [NUM_VOICES-1:0]            voice_active_out,
    output logic [NUM_VOICES*RATE_WIDTH-1:0] voice_rate_out,
    output logic                             steal_out,
    output logic [IW-1:0]                    steal_idx_out,
    output logic [CNTW-1:0]                  active_count_out
);
    localparam int RLW = idx_width(RELEASE_CYCLES);
    localparam logic [RLW-1:0] REL_LOAD = RLW'(RELEASE_CYCLES - 1);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
    ctrl_state_t ctrl;
    voice_state_t [NUM_VOICES-1:0] vstate;
    logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] vnote;
    logic [NUM_VOICES-1:0][RATE_WIDTH-1:0] vrate;
    logic [NUM_VOICES-1:0][AGE_WIDTH-1:0] vage;
    logic [NUM_VOICES-1:0][RLW-1:0] vrel;
    logic [NUM_VOICES-1:0] vsust, held, releasing;
    logic ready, ev_on, sel_steal, steal_r, commit, sus_hold, sus_fall;
    logic [NOTE_WIDTH-1:0] ev_note;
    logic [RATE_WIDTH-1:0] ev_rate;
    logic [IW-1:0] sel_idx, steal_idx_r;
    logic [CNTW-1:0] n_active;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    logic sustain_q;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) sustain_q <= 1'b0;
        else sustain_q <= sustain_in;
    end
    assign sus_hold = sustain_in;
    assign sus_fall = sustain_q & ~sustain_in;
`else
    assign sus_hold = 1'b0;
    assign sus_fall = 1'b0;
`endif
    assign commit = ctrl == ST_COMMIT;
    assign ev.event_ready_out = ready;
    always_comb begin
        held = '0;
        releasing = '0;
        n_active = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            held[v] = vstate[v] == V_HELD;
            releasing[v] = vstate[v] == V_RELEASING;
            n_active = n_active + CNTW'(held[v] | releasing[v]);
        end
    end
    voice_select #(
        .NUM_VOICES(NUM_VOICES),
        .NOTE_WIDTH(NOTE_WIDTH),
        .AGE_WIDTH(AGE_WIDTH)
    ) u_select (
        .held(held),
        .releasing(releasing),
        .notes(vnote),
        .ages(vage),
        .note(ev_note),
        .idx(sel_idx),
        .steal(sel_steal)
    );
    // later assignments in the voice loop override earlier ones: all-off/release first, allocation last
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ctrl <= ST_IDLE;
            ready <= 1'b1;
            ev_on <= 1'b0;
            ev_note <= '0;
            ev_rate <= '0;
            steal_r <= 1'b0;
            steal_idx_r <= '0;
            steal_out <= 1'b0;
            steal_idx_out <= '0;
            active_count_out <= '0;
            voice_gate_out <= '0;
            voice_active_out <= '0;
            voice_rate_out <= '0;
            vnote <= '0;
            vrate <= '0;
            vage <= '0;
            vrel <= '0;
            vsust <= '0;
            for (int v = 0; v < NUM_VOICES; v++) vstate[v] <= V_IDLE;
        end else begin
            ctrl <= (ev.event_valid_in && ready) ? ST_COMMIT : ST_IDLE;
            ready <= !(ev.event_valid_in && ready);
            if (ev.event_valid_in && ready) begin
                ev_on <= ev.note_on_in;
                ev_note <= ev.note_in;
                ev_rate <= ev.rate_in;
            end
            steal_r <= commit && ev_on && sel_steal;
            if (commit && ev_on && sel_steal) steal_idx_r <= sel_idx;
            steal_out <= steal_r;
            steal_idx_out <= steal_idx_r;
            active_count_out <= n_active;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_gate_out[v] <= held[v];
                voice_active_out[v] <= held[v] | releasing[v];
                voice_rate_out[v*RATE_WIDTH +: RATE_WIDTH] <= vrate[v];
                if (vstate[v] != V_IDLE && vage[v] != AGE_MAX) vage[v] <= vage[v] + 1'b1;
                if (releasing[v]) begin
                    if (vrel[v] == '0) begin
                        vstate[v] <= V_IDLE;
                        vrate[v] <= '0;
                        vage[v] <= '0;
                    end else begin
                        vrel[v] <= vrel[v] - 1'b1;
                    end
                end
                if (held[v] && (all_off_in || (sus_fall && vsust[v])
                    || (commit && !ev_on && vnote[v] == ev_note && !sus_hold))) begin
                    vstate[v] <= V_RELEASING;
                    vrel[v] <= REL_LOAD;
                    vsust[v] <= 1'b0;
                end
                if (held[v] && commit && !ev_on && vnote[v] == ev_note && sus_hold && !all_off_in)
                    vsust[v] <= 1'b1;
                if (commit && ev_on && sel_idx == IW'(v)) begin
                    vstate[v] <= V_HELD;
                    vnote[v] <= ev_note;
                    vrate[v] <= ev_rate;
                    vage[v] <= '0;
                    vsust[v] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed scenarios plus random traffic checked every cycle
// against a voice-level behavioural model of the allocator.
module tb_voice_allocator;
    localparam int NV = 4, NW = 7, RW = 24, AW = 4, RC = 8, IW = 2, CW = 3;
    localparam int AMAX = (1 << AW) - 1;
    logic clk_in = 1'b0, rst_in = 1'b1, all_off_in = 1'b0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    logic sustain_in = 1'b0;
`endif
    logic [NV-1:0] voice_gate_out, voice_active_out;
    logic [NV*RW-1:0] voice_rate_out;
    logic steal_out;
    logic [IW-1:0] steal_idx_out;
    logic [CW-1:0] active_count_out;
    voice_allocator_if #(.NOTE_WIDTH(NW), .RATE_WIDTH(RW)) bus();
    voice_allocator #(
        .NUM_VOICES(NV), .NOTE_WIDTH(NW), .RATE_WIDTH(RW), .AGE_WIDTH(AW), .RELEASE_CYCLES(RC)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .ev(bus),
        .all_off_in(all_off_in),
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        .sustain_in(sustain_in),
`endif
        .voice_gate_out(voice_gate_out),
        .voice_active_out(voice_active_out),
        .voice_rate_out(voice_rate_out),
        .steal_out(steal_out),
        .steal_idx_out(steal_idx_out),
        .active_count_out(active_count_out)
    );
    always #5 clk_in = ~clk_in;

    int tests = 0, fails = 0;
    // model: 0 idle, 1 held, 2 releasing; ml = release cycles still to run
    int ms[NV], mn[NV], ma[NV], ml[NV];
    bit msu[NV];
    logic [RW-1:0] mr[NV];
    bit m_ready, pend, p_on, s1_steal, sus_prev;
    int p_note, s1_idx;
    logic [RW-1:0] p_rate;
    logic [NV-1:0] e_gate, e_act;
    logic [NV*RW-1:0] e_rate;
    bit e_steal;
    int e_sidx, e_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit sus_now();
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        return sustain_in;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void pick(output int sel, output bit stl);
        sel = -1;
        stl = 1'b0;
        for (int v = 0; v < NV; v++) if (sel < 0 && ms[v] == 1 && mn[v] == p_note) sel = v;
        for (int v = 0; v < NV; v++) if (sel < 0 && ms[v] == 0) sel = v;
        if (sel < 0) begin
            stl = 1'b1;
            for (int k = 2; k >= 1 && sel < 0; k--)
                for (int v = 0; v < NV; v++)
                    if (ms[v] == k && (sel < 0 || ma[v] > ma[sel])) sel = v;
        end
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            ms[v] = 0; mn[v] = 0; ma[v] = 0; ml[v] = 0; msu[v] = 0; mr[v] = '0;
        end
        m_ready = 1; pend = 0; p_on = 0; p_note = 0; p_rate = '0;
        s1_steal = 0; s1_idx = 0; sus_prev = 0;
        e_gate = '0; e_act = '0; e_rate = '0; e_steal = 0; e_sidx = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        int sel, pre;
        bit stl, com, acc, sus, fall, off_match;
        sus = sus_now();
        fall = sus_prev && !sus;
        e_cnt = 0;
        for (int v = 0; v < NV; v++) begin
            e_gate[v] = ms[v] == 1;
            e_act[v] = ms[v] != 0;
            e_rate[v*RW +: RW] = mr[v];
            e_cnt += (ms[v] != 0) ? 1 : 0;
        end
        e_steal = s1_steal;
        e_sidx = s1_idx;
        com = pend;
        acc = bus.event_valid_in && m_ready;
        pick(sel, stl);
        for (int v = 0; v < NV; v++) begin
            pre = ms[v];
            if (pre != 0 && ma[v] < AMAX) ma[v]++;
            if (pre == 2) begin
                ml[v]--;
                if (ml[v] == 0) begin ms[v] = 0; mr[v] = '0; ma[v] = 0; end
            end
            off_match = pre == 1 && com && !p_on && mn[v] == p_note;
            if (pre == 1 && (all_off_in || (fall && msu[v]) || (off_match && !sus))) begin
                ms[v] = 2; ml[v] = RC; msu[v] = 0;
            end
            if (off_match && sus && !all_off_in) msu[v] = 1;
            if (com && p_on && sel == v) begin
                ms[v] = 1; mn[v] = p_note; mr[v] = p_rate; ma[v] = 0; msu[v] = 0;
            end
        end
        if (com && p_on && stl) s1_idx = sel;
        s1_steal = com && p_on && stl;
        if (acc) begin
            p_on = bus.note_on_in; p_note = int'(bus.note_in); p_rate = bus.rate_in;
        end
        pend = acc;
        m_ready = !acc;
        sus_prev = sus;
    endtask

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) model_reset();
        else model_step();
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            chk("gate", voice_gate_out, e_gate);
            chk("active", voice_active_out, e_act);
            chk("rate", voice_rate_out, e_rate);
            chk("count", active_count_out, e_cnt);
            chk("steal", steal_out, e_steal);
            chk("ready", bus.event_ready_out, m_ready);
            if (e_steal) chk("steal_idx", steal_idx_out, e_sidx);
        end
    end

    task automatic send(input bit on, input int note, input int rate);
        int n = 0;
        bus.event_valid_in = 1'b1;
        bus.note_on_in = on;
        bus.note_in = NW'(note);
        bus.rate_in = RW'(rate);
        while (!bus.event_ready_out && n < 8) begin
            @(negedge clk_in);
            n++;
        end
        if (n == 8) chk("ready_timeout", 1'b0, 1'b1);
        @(negedge clk_in);
        bus.event_valid_in = 1'b0;
    endtask

    task automatic pulse_all_off();
        all_off_in = 1'b1;
        @(negedge clk_in);
        all_off_in = 1'b0;
    endtask

    task automatic settle();
        pulse_all_off();
        repeat (RC + 4) @(negedge clk_in);
    endtask

    initial begin
        bus.event_valid_in = 1'b0;
        bus.note_on_in = 1'b0;
        bus.note_in = '0;
        bus.rate_in = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_ready", bus.event_ready_out, 1'b1);
        chk("rst_active", voice_active_out, 0);
        chk("rst_count", active_count_out, 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        // release lifecycle
        send(1, 60, 500);
        repeat (2) @(negedge clk_in);
        send(0, 60, 0);
        repeat (2) @(negedge clk_in);
        chk("rel_gate", voice_gate_out[0], 1'b0);
        chk("rel_active", voice_active_out[0], 1'b1);
        repeat (7) @(negedge clk_in);
        chk("rel_active_last", voice_active_out[0], 1'b1);
        @(negedge clk_in);
        chk("rel_idle", {voice_active_out[0], voice_rate_out[RW-1:0]}, 0);
        // retrigger
        send(1, 60, 1000);
        send(1, 60, 1200);
        repeat (2) @(negedge clk_in);
        chk("retrig_rate", voice_rate_out[RW-1:0], 1200);
        chk("retrig_count", active_count_out, 1);
        chk("retrig_steal", steal_out, 1'b0);
        settle();
        // fill and steal
        send(1, 60, 10); send(1, 62, 20); send(1, 64, 30); send(1, 65, 40); send(1, 67, 50);
        repeat (2) @(negedge clk_in);
        chk("fill_steal", steal_out, 1'b1);
        chk("fill_idx", steal_idx_out, 0);
        chk("fill_count", active_count_out, 4);
        chk("fill_rate0", voice_rate_out[RW-1:0], 50);
        // releasing voice preferred over held
        send(0, 64, 0);
        send(1, 70, 60);
        repeat (2) @(negedge clk_in);
        chk("relpref_steal", steal_out, 1'b1);
        chk("relpref_idx", steal_idx_out, 2);
        settle();
        // saturated ages tie -> lowest index even though voice 0 is youngest
        send(1, 50, 1); send(1, 51, 2); send(1, 52, 3); send(1, 53, 4); send(1, 50, 5);
        repeat (20) @(negedge clk_in);
        send(1, 90, 6);
        repeat (2) @(negedge clk_in);
        chk("sat_tie_idx", steal_idx_out, 0);
        settle();
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        sustain_in = 1'b1;
        send(1, 60, 7);
        send(0, 60, 0);
        repeat (2) @(negedge clk_in);
        chk("sus_gate_held", voice_gate_out[0], 1'b1);
        sustain_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("sus_released", {voice_gate_out[0], voice_active_out[0]}, 2'b01);
        repeat (RC) @(negedge clk_in);
        chk("sus_idle", voice_active_out[0], 1'b0);
`endif
        // random traffic
        for (int c = 0; c < 800; c++) begin
            bus.event_valid_in = $urandom_range(0, 2) == 0;
            bus.note_on_in = $urandom_range(0, 2) != 0;
            bus.note_in = NW'($urandom_range(60, 65));
            bus.rate_in = RW'($urandom);
            all_off_in = $urandom_range(0, 40) == 0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            if ($urandom_range(0, 25) == 0) sustain_in = ~sustain_in;
`endif
            @(negedge clk_in);
        end
        bus.event_valid_in = 1'b0;
        all_off_in = 1'b0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        sustain_in = 1'b0;
`endif
        settle();
        // asynchronous reset mid-operation
        send(1, 40, 11); send(1, 41, 12); send(1, 42, 13);
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_gate", voice_gate_out, 0);
        chk("arst_active", voice_active_out, 0);
        chk("arst_rate", voice_rate_out, 0);
        chk("arst_count", active_count_out, 0);
        chk("arst_ready", bus.event_ready_out, 1'b1);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
